// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: op codes,
// FSM states and the default datapath width.
package muldiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on magnitudes.
// acc is {upper, multiplier} for multiply and {remainder, quotient} for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] prod;
  logic             fits;

  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign prod = acc[0] ? {sum, acc[WIDTH-1:0]} : {1'b0, acc};

  // Shifted remainder needs one extra bit before the trial subtract.
  assign sh   = acc[2*WIDTH-1:WIDTH-1];
  assign diff = sh - {1'b0, opnd};
  assign fits = (sh >= {1'b0, opnd});

  always_comb begin
    acc_next = prod[2*WIDTH:1];
    if (is_div) begin
      if (fits) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else      acc_next = {sh[WIDTH-1:0],   acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; stalls EX when a new op or an
// MFHI/MFLO read would collide with an operation still in flight.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d1_in,
  input  logic [WIDTH-1:0] d2_in,
  input  logic [2:0]       op_in,
  input  logic             rd_req_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             stall_out
);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res, neg_rem, div_zero;

  logic               sgn_op, div_op, op_valid;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign sgn_op   = (op_in == MD_MULT) || (op_in == MD_DIV);
  assign div_op   = (op_in == MD_DIV) || (op_in == MD_DIVU);
  assign mag1     = (sgn_op && d1_in[WIDTH-1]) ? -d1_in : d1_in;
  assign mag2     = (sgn_op && d2_in[WIDTH-1]) ? -d2_in : d2_in;
  assign op_valid = (op_in != MD_NONE) && (op_in != 3'b111);

  assign stall_out = busy_out && (op_valid || rd_req_in);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  // Divide-by-zero leaves |dividend| in the remainder, so the sign fix restores d1.
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          case (op_in)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              acc      <= div_op ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
              opnd     <= div_op ? mag2 : mag1;
              is_div   <= div_op;
              neg_res  <= sgn_op && (d1_in[WIDTH-1] ^ d2_in[WIDTH-1]);
              neg_rem  <= sgn_op && d1_in[WIDTH-1];
              div_zero <= div_op && (d2_in == '0);
              cnt      <= '0;
              busy_out <= 1'b1;
              state    <= ST_CALC;
            end
            MD_MTHI: hi_out <= d1_in;
            MD_MTLO: lo_out <= d1_in;
            default: ;
          endcase
        end
        ST_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            cnt   <= '0;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div) begin
            hi_out <= rem_fix;
            lo_out <= quot_fix;
          end else begin
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
            lo_out <= prod_fix[WIDTH-1:0];
          end
          busy_out <= 1'b0;
          done_out <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: vector table, hand-written stall/reset sequences and
// random ops against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d1_in, d2_in;
  logic [2:0]  op_in;
  logic        rd_req_in;
  logic [31:0] hi_out, lo_out;
  logic        busy_out, done_out, stall_out;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .d1_in     (d1_in),
    .d2_in     (d2_in),
    .op_in     (op_in),
    .rd_req_in (rd_req_in),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .stall_out (stall_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit signed/unsigned arithmetic, division truncates toward zero.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    if (op == MD_MULT) res = 64'(sa * sb);
    else if (op == MD_MULTU) res = ua * ub;
    else if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
    else if (op == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int bad;
    @(negedge clk);
    op_in = op; d1_in = a; d2_in = b; rd_req_in = 1'b0;
    #1 chk({name, " idle_stall"}, {31'b0, stall_out}, 32'd0);
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      op_in = MD_NONE;
      if (busy_out !== 1'b1 || done_out !== 1'b0) bad++;
    end
    chk({name, " busy_window"}, bad, 0);
    @(negedge clk);
    chk({name, " busy_done_T34"}, {30'b0, busy_out, done_out}, 32'd1);
    chk({name, " hi"}, hi_out, ehi);
    chk({name, " lo"}, lo_out, elo);
    @(negedge clk);
    chk({name, " done_pulse_end"}, {31'b0, done_out}, 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] exp;
    int          sbad, dcnt;

    tbl[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{MD_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
    tbl[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    tbl[5] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    tbl[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    tbl[8] = '{MD_DIVU,  32'd7,         32'd13,       32'd7,         32'd0};
    tbl[9] = '{MD_MULT,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};

    rst = 1'b1; op_in = MD_NONE; d1_in = '0; d2_in = '0; rd_req_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rd_req_in = 1'b1;
    #1;
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    chk("reset busy_done_stall", {29'b0, busy_out, done_out, stall_out}, 32'd0);

    // MTHI with a simultaneous read in IDLE, then MTLO on the next cycle.
    @(negedge clk);
    op_in = MD_MTHI; d1_in = 32'hA5A5_A5A5; rd_req_in = 1'b1;
    #1 chk("mthi stall", {31'b0, stall_out}, 32'd0);
    chk("mthi read sees old hi", hi_out, 32'd0);
    @(negedge clk);
    op_in = MD_MTLO; d1_in = 32'h5A5A_5A5A; rd_req_in = 1'b0;
    #1 chk("mthi hi", hi_out, 32'hA5A5_A5A5);
    chk("mtlo stall", {31'b0, stall_out}, 32'd0);
    @(negedge clk);
    op_in = MD_NONE;
    chk("mtlo lo", lo_out, 32'h5A5A_5A5A);
    chk("mt no done", {31'b0, done_out}, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].d1, tbl[i].d2, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));

    // Read from T+5 and MTLO from T+10 held across a MULT.
    @(negedge clk);
    op_in = MD_MULT; d1_in = 32'd5; d2_in = 32'd6;
    sbad = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      op_in     = (k >= 10) ? MD_MTLO : MD_NONE;
      d1_in     = (k >= 10) ? 32'h1234 : 32'd5;
      rd_req_in = (k >= 5);
      #1;
      if (stall_out !== (k >= 5 && k <= 33)) sbad++;
    end
    chk("stall window", sbad, 0);
    chk("stall done T34", {31'b0, done_out}, 32'd1);
    chk("stall mult lo", lo_out, 32'd30);
    @(negedge clk);
    op_in = MD_NONE; rd_req_in = 1'b0;
    chk("held mtlo lo", lo_out, 32'h1234);
    chk("held mtlo hi", hi_out, 32'd0);

    // Reset in the middle of a DIV.
    @(negedge clk);
    op_in = MD_DIV; d1_in = 32'hFFFF_FFF9; d2_in = 32'd2;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      op_in = MD_NONE;
      if (k == 12) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'b0, busy_out}, 32'd0);
    chk("abort hi", hi_out, 32'd0);
    chk("abort lo", lo_out, 32'd0);
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_out !== 1'b0 || busy_out !== 1'b0) dcnt++;
    end
    chk("abort no done", dcnt, 0);
    run_op(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "post_abort");

    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      if (i % 4 == 0) ra = 32'($signed(-$urandom_range(1, 1000)));
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d op%0d %h %h", i, rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
